// File: rtl/frame_head_detect.sv
// Hunts BB66 + fill-word frame heads, strips them and forwards PAYLOAD_LEN words with sof/eof (fill check: FRAME_HEAD_FILL_CHECK_EN).
// Latency: 1 cycle from an accepted word to o_data/o_data_vld/o_sof/o_eof; o_head_err the cycle after the bad word.
// Backpressure: none; a word is accepted on every cycle with i_data_vld high, invalid cycles hold all state.
module frame_head_detect #(
    parameter int          DW          = 16,
    parameter int          HEAD_LENGTH = 32,
    parameter int          PAYLOAD_LEN = 49152,
    parameter logic [15:0] SYNC_WORD   = 16'hBB66,
    parameter logic [15:0] FILL_WORD   = 16'hFFFF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_data_vld,
    output logic [DW-1:0] o_data,
    output logic          o_data_vld,
    output logic          o_sof,
    output logic          o_eof,
    output logic          o_head_err,
    output logic [15:0]   o_frame_cnt
);
    localparam int HW = $clog2(HEAD_LENGTH + 1);
    localparam int PW = $clog2(PAYLOAD_LEN + 1);
    localparam logic [DW-1:0] SYNC_EXT  = DW'(SYNC_WORD);
    localparam logic [DW-1:0] FILL_EXT  = DW'(FILL_WORD);
    localparam logic [HW-1:0] HEAD_ONE  = HW'(1);
    localparam logic [HW-1:0] HEAD_LAST = HW'(HEAD_LENGTH);
    localparam logic [PW-1:0] PAY_ONE   = PW'(1);
    localparam logic [PW-1:0] PAY_LAST  = PW'(PAYLOAD_LEN);
`ifdef FRAME_HEAD_FILL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PAYLOAD} state_t;

    // A one-word head has no fill phase, so a sync jumps straight to payload.
    localparam state_t SYNC_NEXT = (HEAD_LENGTH == 1) ? S_PAYLOAD : S_HEAD;

    state_t        state_q, state_d;
    logic [HW-1:0] head_cnt_q, head_cnt_d;
    logic [PW-1:0] pay_cnt_q, pay_cnt_d;
    logic [DW-1:0] data_d;
    logic          vld_d, sof_d, eof_d, err_d;
    logic [15:0]   frame_cnt_d;
    logic          is_sync, fill_bad;

    assign is_sync  = (i_data == SYNC_EXT);
    assign fill_bad = CHECK_EN && (i_data != FILL_EXT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            head_cnt_q  <= '0;
            pay_cnt_q   <= '0;
            o_data      <= '0;
            o_data_vld  <= 1'b0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_head_err  <= 1'b0;
            o_frame_cnt <= 16'd0;
        end else begin
            state_q     <= state_d;
            head_cnt_q  <= head_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            o_data      <= data_d;
            o_data_vld  <= vld_d;
            o_sof       <= sof_d;
            o_eof       <= eof_d;
            o_head_err  <= err_d;
            o_frame_cnt <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        head_cnt_d  = head_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        data_d      = '0;
        vld_d       = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = o_frame_cnt;
        if (i_data_vld) begin
            case (state_q)
                S_IDLE: begin
                    if (is_sync) begin
                        head_cnt_d = HEAD_ONE;
                        pay_cnt_d  = '0;
                        state_d    = SYNC_NEXT;
                    end
                end
                S_HEAD: begin
                    if (fill_bad) begin
                        // A sync in place of a fill word restarts the head instead of dropping it.
                        err_d = 1'b1;
                        if (is_sync) begin
                            head_cnt_d = HEAD_ONE;
                            state_d    = SYNC_NEXT;
                        end else begin
                            head_cnt_d = '0;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        head_cnt_d = head_cnt_q + HEAD_ONE;
                        if (head_cnt_q + HEAD_ONE == HEAD_LAST) begin
                            state_d = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    data_d    = i_data;
                    vld_d     = 1'b1;
                    sof_d     = (pay_cnt_q == '0);
                    pay_cnt_d = pay_cnt_q + PAY_ONE;
                    if (pay_cnt_q + PAY_ONE == PAY_LAST) begin
                        eof_d       = 1'b1;
                        frame_cnt_d = o_frame_cnt + 16'd1;
                        pay_cnt_d   = '0;
                        head_cnt_d  = '0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_head_detect.sv
// Directed bench for frame_head_detect with a short payload; expectations follow the
// fill-check build option so the same stimulus covers both configurations.
module tb_frame_head_detect;
    localparam int PL = 200;
    localparam int HL = 32;
`ifdef FRAME_HEAD_FILL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [15:0] i_data = 16'h0;
    logic        i_data_vld = 1'b0;
    logic [15:0] o_data;
    logic        o_data_vld, o_sof, o_eof, o_head_err;
    logic [15:0] o_frame_cnt;

    int total = 0;
    int bad   = 0;

    // Expected outputs for the word driven on the previous step.
    logic [15:0] p_dat = 16'h0;
    logic        p_vld = 1'b0, p_sof = 1'b0, p_eof = 1'b0, p_err = 1'b0;

    frame_head_detect #(
        .DW(16), .HEAD_LENGTH(HL), .PAYLOAD_LEN(PL),
        .SYNC_WORD(16'hBB66), .FILL_WORD(16'hFFFF)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_data_vld(i_data_vld),
        .o_data(o_data), .o_data_vld(o_data_vld), .o_sof(o_sof), .o_eof(o_eof),
        .o_head_err(o_head_err), .o_frame_cnt(o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pending();
        cmp("o_data_vld", 32'(o_data_vld), 32'(p_vld));
        cmp("o_data",     32'(o_data),     32'(p_dat));
        cmp("o_sof",      32'(o_sof),      32'(p_sof));
        cmp("o_eof",      32'(o_eof),      32'(p_eof));
        cmp("o_head_err", 32'(o_head_err), 32'(p_err));
    endtask

    task automatic step(input logic [15:0] d, input logic v, input logic ex,
                        input logic es, input logic ee, input logic er);
        @(negedge i_clk);
        chk_pending();
        i_data     = d;
        i_data_vld = v;
        p_vld      = ex;
        p_dat      = ex ? d : 16'h0;
        p_sof      = es;
        p_eof      = ee;
        p_err      = er;
    endtask

    task automatic idle(input int n);
        repeat (n) step(16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic head(input int nfill, input bit toggle);
        if (toggle && $urandom_range(0, 1) == 1) idle(1);
        step(16'hBB66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < nfill; k++) begin
            if (toggle && $urandom_range(0, 1) == 1) idle(1);
            step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // pre fill words spill into the payload; words past PL fall back into the hunt and are dropped.
    task automatic pay(input logic [15:0] base, input int pre, input bit toggle);
        for (int k = 0; k < pre + PL; k++) begin
            logic [15:0] d;
            logic        ex;
            d  = (k < pre) ? 16'hFFFF : base + 16'(k - pre);
            ex = (k < PL);
            if (toggle && $urandom_range(0, 1) == 1) idle(1);
            step(d, 1'b1, ex, ex && (k == 0), ex && (k == PL - 1), 1'b0);
        end
    endtask

    initial begin
        #2 i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        cmp("rst_o_data",      32'(o_data),      32'h0);
        cmp("rst_o_data_vld",  32'(o_data_vld),  32'h0);
        cmp("rst_o_sof",       32'(o_sof),       32'h0);
        cmp("rst_o_eof",       32'(o_eof),       32'h0);
        cmp("rst_o_head_err",  32'(o_head_err),  32'h0);
        cmp("rst_o_frame_cnt", 32'(o_frame_cnt), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Non-sync noise while hunting, then a clean frame.
        step(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(16'h0BB6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        head(HL - 1, 1'b0);
        pay(16'h0000, 0, 1'b0);
        idle(2);
        cmp("frame_cnt_clean", 32'(o_frame_cnt), 32'd1);

        // Same frame with valid toggled.
        head(HL - 1, 1'b1);
        pay(16'h1000, 0, 1'b1);
        idle(2);
        cmp("frame_cnt_toggle", 32'(o_frame_cnt), 32'd2);

        // Head broken by 1234 after 10 fills; without the check the words are just counted.
        step(16'hBB66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, CHK);
        step(16'hBB66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (CHK ? 31 : 19) step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pay(16'h2000, CHK ? 0 : 12, 1'b0);
        idle(2);
        cmp("frame_cnt_abort", 32'(o_frame_cnt), 32'd3);

        // Second sync after 5 fills.
        step(16'hBB66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(16'hBB66, 1'b1, 1'b0, 1'b0, 1'b0, CHK);
        repeat (CHK ? 31 : 25) step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pay(16'h3000, CHK ? 0 : 6, 1'b0);
        idle(2);
        cmp("frame_cnt_resync", 32'(o_frame_cnt), 32'd4);

        // BB66 inside the payload (word 6), then a back-to-back frame.
        head(HL - 1, 1'b0);
        pay(16'hBB60, 0, 1'b0);
        head(HL - 1, 1'b0);
        pay(16'h4000, 0, 1'b0);
        idle(2);
        cmp("frame_cnt_b2b", 32'(o_frame_cnt), 32'd6);

        // Reset in the middle of a payload.
        head(HL - 1, 1'b0);
        for (int k = 0; k < 100; k++) begin
            step(16'h5000 + 16'(k), 1'b1, 1'b1, k == 0, 1'b0, 1'b0);
        end
        @(negedge i_clk);
        chk_pending();
        i_rst      = 1'b1;
        i_data_vld = 1'b0;
        #1;
        cmp("midrst_o_data",      32'(o_data),      32'h0);
        cmp("midrst_o_data_vld",  32'(o_data_vld),  32'h0);
        cmp("midrst_o_eof",       32'(o_eof),       32'h0);
        cmp("midrst_o_head_err",  32'(o_head_err),  32'h0);
        cmp("midrst_o_frame_cnt", 32'(o_frame_cnt), 32'h0);
        p_vld = 1'b0; p_dat = 16'h0; p_sof = 1'b0; p_eof = 1'b0; p_err = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        idle(2);
        head(HL - 1, 1'b0);
        pay(16'h6000, 0, 1'b0);
        idle(2);
        cmp("frame_cnt_after_rst", 32'(o_frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
